// File: rtl/env_irq_gen_pkg.sv
// rtl/env_irq_gen_pkg.sv - register offsets and bit positions shared by env_irq_gen
package env_irq_gen_pkg;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_RLD_LO = 3'd1,
    REG_RLD_HI = 3'd2,
    REG_VEC    = 3'd3,
    REG_STAT   = 3'd4
  } reg_ofs_e;

  localparam int NUM_REGS = 5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_NMI_SEL = 2;

  localparam int STAT_PEND = 0;
  localparam int STAT_EN   = 1;

endpackage

// File: rtl/env_irq_gen_if.sv
// rtl/env_irq_gen_if.sv - TV80 I/O bus slice seen by env_irq_gen
interface env_irq_gen_if;
  logic       m1_n;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_oe;

  modport master (output m1_n, iorq_n, rd_n, wr_n, addr, wr_data,
                  input  rd_data, rd_oe);
  modport slave  (input  m1_n, iorq_n, rd_n, wr_n, addr, wr_data,
                  output rd_data, rd_oe);
endinterface

// File: rtl/env_irq_gen_timer.sv
// rtl/env_irq_gen_timer.sv - prescaler plus 16-bit reload down-counter
module env_irq_gen_timer #(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        load,
  input  logic        reload,
  input  logic [15:0] rld_val,
  output logic        expire
);

  logic [15:0] pre;
  logic [15:0] cnt;
  logic        tick;

  assign tick = en & (pre == 16'(PRESCALE - 1));
  // A zero reload value keeps the counter parked at 0, so every tick expires.
  assign expire = tick & ((cnt == 16'd1) | ((cnt == 16'd0) & (rld_val == 16'd0)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= 16'd0;
      cnt <= 16'd0;
    end else if (load) begin
      pre <= 16'd0;
      cnt <= rld_val;
    end else if (en) begin
      if (tick) begin
        pre <= 16'd0;
        cnt <= (expire & reload) ? rld_val : cnt - 16'd1;
      end else begin
        pre <= pre + 16'd1;
      end
    end
  end

endmodule

// File: rtl/env_irq_gen.sv
// rtl/env_irq_gen.sv - I/O-mapped timer interrupt source with IM2 ack and NMI pulse
module env_irq_gen
  import env_irq_gen_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h90,
  parameter int         PRESCALE  = 16,
  parameter int         NMI_PULSE = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  env_irq_gen_if.slave  bus,
  output logic          int_n,
  output logic          nmi_n
);

  localparam int NMI_W = (NMI_PULSE > 1) ? $clog2(NMI_PULSE) : 1;

  logic [2:0]       ctrl_q;
  logic [7:0]       rld_lo, rld_hi, vec;
  logic             pend;
  logic             wr_done, ack_seen, ack_ok;
  logic [NMI_W-1:0] nmi_cnt;

  logic [7:0] ofs;
  reg_ofs_e   reg_sel;
  logic       hit, wr_cyc, rd_cyc, wr_fire, ctrl_wr;
  logic       en, reload, nmi_sel;
  logic       timer_load, expire_raw, expire;
  logic       ack_win, ack_first, ack_rd;
  logic       pend_set, pend_clr;
  logic [7:0] reg_rd, stat_val;

  assign ofs     = bus.addr - BASE_ADDR;
  assign hit     = ofs < 8'(NUM_REGS);
  assign reg_sel = reg_ofs_e'(ofs[2:0]);
  assign wr_cyc  = ~bus.iorq_n & bus.m1_n & hit & ~bus.wr_n;
  assign rd_cyc  = ~bus.iorq_n & bus.m1_n & hit & ~bus.rd_n & reset_n;
  // Only the first edge of a write strobe acts; wr_done holds until iorq_n rises.
  assign wr_fire = wr_cyc & ~wr_done;
  assign ctrl_wr = wr_fire & (reg_sel == REG_CTRL);

  assign en      = ctrl_q[CTRL_EN];
  assign reload  = ctrl_q[CTRL_RELOAD];
  assign nmi_sel = ctrl_q[CTRL_NMI_SEL];

  assign timer_load = ctrl_wr & bus.wr_data[CTRL_EN] & ~en;
  assign expire     = expire_raw & ~ctrl_wr;

  // Ack acceptance is decided on the first edge and remembered for the window.
  assign ack_win   = ~bus.m1_n & ~bus.iorq_n;
  assign ack_first = ack_win & ~ack_seen;
  assign ack_rd    = reset_n & ack_win & (ack_seen ? ack_ok : pend);

  assign pend_set = expire & ~nmi_sel;
  assign pend_clr = ack_first |
                    (wr_fire & (reg_sel == REG_STAT) & bus.wr_data[STAT_PEND]);

  env_irq_gen_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .load    (timer_load),
    .reload  (reload),
    .rld_val ({rld_hi, rld_lo}),
    .expire  (expire_raw)
  );

  always_comb begin
    stat_val            = 8'h00;
    stat_val[STAT_PEND] = pend;
    stat_val[STAT_EN]   = en;
    reg_rd              = 8'h00;
    case (reg_sel)
      REG_CTRL:   reg_rd = {5'b0, ctrl_q};
      REG_RLD_LO: reg_rd = rld_lo;
      REG_RLD_HI: reg_rd = rld_hi;
      REG_VEC:    reg_rd = vec;
      REG_STAT:   reg_rd = stat_val;
      default:    reg_rd = 8'h00;
    endcase
  end

  assign bus.rd_oe   = rd_cyc | ack_rd;
  assign bus.rd_data = ack_rd ? vec : (rd_cyc ? reg_rd : 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= 3'b000;
      rld_lo   <= 8'h00;
      rld_hi   <= 8'h00;
      vec      <= 8'h00;
      pend     <= 1'b0;
      wr_done  <= 1'b0;
      ack_seen <= 1'b0;
      ack_ok   <= 1'b0;
      nmi_cnt  <= '0;
      int_n    <= 1'b1;
      nmi_n    <= 1'b1;
    end else begin
      wr_done  <= bus.iorq_n ? 1'b0 : (wr_done | wr_cyc);
      ack_seen <= ack_win;
      ack_ok   <= ack_win & (ack_seen ? ack_ok : pend);

      if (ctrl_wr)
        ctrl_q <= bus.wr_data[2:0];
      else if (expire & ~reload)
        ctrl_q[CTRL_EN] <= 1'b0;

      if (wr_fire & (reg_sel == REG_RLD_LO)) rld_lo <= bus.wr_data;
      if (wr_fire & (reg_sel == REG_RLD_HI)) rld_hi <= bus.wr_data;
      if (wr_fire & (reg_sel == REG_VEC))    vec    <= bus.wr_data;

      if (pend_set)
        pend <= 1'b1;
      else if (pend_clr)
        pend <= 1'b0;

      int_n <= ~(pend & ~nmi_sel);

      // A new expiry restarts the count while nmi_n stays low: no extra edge.
      if (expire & nmi_sel) begin
        nmi_n   <= 1'b0;
        nmi_cnt <= NMI_W'(NMI_PULSE - 1);
      end else if (nmi_cnt != '0) begin
        nmi_cnt <= nmi_cnt - NMI_W'(1);
      end else begin
        nmi_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_env_irq_gen.sv
// tb/tb_env_irq_gen.sv - directed self-checking bench for env_irq_gen
module tb_env_irq_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic int_n, nmi_n;
  int   cyc = 0;
  int   wr_edge = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  env_irq_gen_if bus ();

  env_irq_gen #(.BASE_ADDR(8'h90), .PRESCALE(16), .NMI_PULSE(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .int_n   (int_n),
    .nmi_n   (nmi_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_data;
    logic       exp_oe;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int hold);
    bus.addr = a; bus.wr_data = d; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    @(posedge clk); #1; wr_edge = cyc;
    for (int i = 1; i < hold; i++) @(posedge clk);
    @(negedge clk);
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    bus.addr = a; bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    #1; d = bus.rd_data; oe = bus.rd_oe;
    @(negedge clk);
    bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_int_fall(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (int_n === 1'b0) begin c = cyc; break; end
    end
  endtask

  task automatic wait_nmi_fall(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (nmi_n === 1'b0) begin c = cyc; break; end
    end
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge clk);
    check("align", cyc, target);
  endtask

  initial begin
    logic [7:0] d, ra;
    logic       oe;
    int         e0, f1, f2, c, w, lows, ilow;

    bus.m1_n = 1'b1; bus.iorq_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.addr = 8'h00; bus.wr_data = 8'h00;

    vt[0] = '{1'b1, 8'h91, 8'h34, 8'h34, 1'b1};
    vt[1] = '{1'b1, 8'h92, 8'h12, 8'h12, 1'b1};
    vt[2] = '{1'b1, 8'h93, 8'hA4, 8'hA4, 1'b1};
    vt[3] = '{1'b1, 8'h90, 8'hF8, 8'h00, 1'b1};
    vt[4] = '{1'b1, 8'h90, 8'h06, 8'h06, 1'b1};
    vt[5] = '{1'b1, 8'h95, 8'hFF, 8'h00, 1'b0};
    vt[6] = '{1'b0, 8'h8F, 8'h00, 8'h00, 1'b0};
    vt[7] = '{1'b1, 8'h94, 8'h01, 8'h00, 1'b1};
    vt[8] = '{1'b1, 8'h90, 8'h00, 8'h00, 1'b1};
    vt[9] = '{1'b0, 8'h91, 8'h00, 8'h34, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_int_n", 32'(int_n), 1);
    check("rst_nmi_n", 32'(nmi_n), 1);
    check("rst_rd_oe", 32'(bus.rd_oe), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) io_write(vt[i].addr, vt[i].wdata, 1);
      io_read(vt[i].addr, d, oe);
      check($sformatf("vec%0d_data", i), 32'(d), 32'(vt[i].exp_data));
      check($sformatf("vec%0d_oe", i), 32'(oe), 32'(vt[i].exp_oe));
    end

    // periodic INT and IM2 ack
    io_write(8'h91, 8'h03, 1);
    io_write(8'h92, 8'h00, 1);
    io_write(8'h90, 8'h03, 1);
    e0 = wr_edge;
    wait_int_fall(f1);
    check("int_first_fall", f1 - e0, 49);
    io_read(8'h94, d, oe);
    check("stat_en_pend", 32'(d), 32'h03);
    io_write(8'h94, 8'h01, 1);
    check("int_n_after_w1c", 32'(int_n), 1);
    wait_int_fall(f2);
    check("int_period", f2 - f1, 48);

    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ack_oe", 32'(bus.rd_oe), 1);
      check("ack_vec", 32'(bus.rd_data), 32'hA4);
      if (i == 2) check("int_n_after_ack", 32'(int_n), 1);
      @(negedge clk);
    end
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    @(negedge clk);
    io_read(8'h94, d, oe);
    check("stat_after_ack", 32'(d), 32'h02);
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    #1;
    check("ack2_oe", 32'(bus.rd_oe), 0);
    check("ack2_data", 32'(bus.rd_data), 0);
    @(negedge clk);
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    @(negedge clk);
    io_write(8'h90, 8'h00, 1);
    io_write(8'h94, 8'h01, 1);

    // NMI one-shot
    io_write(8'h91, 8'h02, 1);
    io_write(8'h90, 8'h05, 1);
    e0 = wr_edge;
    wait_nmi_fall(c);
    check("nmi_start", c - e0, 32);
    w = 0; ilow = 0;
    while (nmi_n === 1'b0 && w < 50) begin
      w++;
      if (int_n !== 1'b1) ilow++;
      @(negedge clk);
    end
    check("nmi_width", w, 4);
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (nmi_n !== 1'b1) lows++;
      if (int_n !== 1'b1) ilow++;
    end
    check("nmi_single_pulse", lows, 0);
    check("nmi_int_quiet", ilow, 0);
    io_read(8'h94, d, oe);
    check("nmi_stat", 32'(d), 32'h00);
    io_read(8'h90, d, oe);
    check("nmi_ctrl", 32'(d), 32'h04);

    // expiry on the same edge as the ack's first edge: set wins
    io_write(8'h91, 8'h01, 1);
    io_write(8'h90, 8'h03, 1);
    e0 = wr_edge;
    wait_int_fall(f1);
    check("coll_first_fall", f1 - e0, 17);
    wait_until(e0 + 31);
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    #1;
    check("coll_ack_oe", 32'(bus.rd_oe), 1);
    @(negedge clk);
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    @(negedge clk);
    check("coll_ack_int_n", 32'(int_n), 0);
    io_read(8'h94, d, oe);
    check("coll_ack_stat", 32'(d), 32'h03);
    io_write(8'h90, 8'h00, 1);
    io_write(8'h94, 8'h01, 1);
    io_read(8'h94, d, oe);
    check("coll_cleanup_stat", 32'(d), 32'h00);

    // expiry on the same edge as a CTRL write: the write wins
    io_write(8'h90, 8'h03, 1);
    e0 = wr_edge;
    wait_until(e0 + 15);
    io_write(8'h90, 8'h00, 1);
    check("coll_wr_edge", wr_edge - e0, 16);
    io_read(8'h94, d, oe);
    check("coll_wr_stat", 32'(d), 32'h00);
    check("coll_wr_int_n", 32'(int_n), 1);

    // held write strobe: single enable load
    io_write(8'h91, 8'h03, 1);
    io_write(8'h90, 8'h01, 4);
    e0 = wr_edge;
    wait_int_fall(f1);
    check("strobe_fall", f1 - e0, 49);
    io_read(8'h94, d, oe);
    check("strobe_stat", 32'(d), 32'h01);
    io_write(8'h94, 8'h01, 1);

    // reset mid NMI pulse and mid ack
    io_write(8'h91, 8'h01, 1);
    io_write(8'h90, 8'h07, 1);
    wait_nmi_fall(c);
    check("mid_nmi_seen", 32'(c > 0), 1);
    @(negedge clk);
    reset_n = 1'b0; bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    #1;
    check("mid_rst_nmi_n", 32'(nmi_n), 1);
    check("mid_rst_int_n", 32'(int_n), 1);
    check("mid_rst_rd_oe", 32'(bus.rd_oe), 0);
    @(negedge clk);
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 5; a++) begin
      ra = 8'(8'h90 + a);
      io_read(ra, d, oe);
      check($sformatf("rst_reg%0d", a), 32'(d), 0);
      check($sformatf("rst_reg%0d_oe", a), 32'(oe), 1);
    end
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (nmi_n !== 1'b1 || int_n !== 1'b1) lows++;
    end
    check("post_rst_quiet", lows, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
